// File: rtl/register_file.sv
// Two-read, one-write register file with registered reads, write-first bypass
// and a stall hold on the read outputs. Register 0 always reads as zero.
module register_file #(
    parameter int word_size = 32,
    parameter int addr_size = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 write_enable,
    input  logic [addr_size-1:0] write_addr,
    input  logic [word_size-1:0] write_data,
    input  logic [addr_size-1:0] read_addr0,
    input  logic [addr_size-1:0] read_addr1,
    output logic [word_size-1:0] read_data0,
    output logic [word_size-1:0] read_data1
);

    localparam int depth = 1 << addr_size;

    logic [word_size-1:0] regs_q [depth];
    logic [word_size-1:0] regs_d [depth];
    logic [word_size-1:0] read_data0_q, read_data0_d;
    logic [word_size-1:0] read_data1_q, read_data1_d;

    // Reads index the post-write array, which gives write-first bypass for free.
    always_comb begin
        regs_d       = regs_q;
        read_data0_d = read_data0_q;
        read_data1_d = read_data1_q;

        if (write_enable && (write_addr != '0)) begin
            regs_d[write_addr] = write_data;
        end
        regs_d[0] = '0;

        if (!stall) begin
            read_data0_d = regs_d[read_addr0];
            read_data1_d = regs_d[read_addr1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '{default: '0};
            read_data0_q <= '0;
            read_data1_q <= '0;
        end else begin
            regs_q       <= regs_d;
            read_data0_q <= read_data0_d;
            read_data1_q <= read_data1_d;
        end
    end

    assign read_data0 = read_data0_q;
    assign read_data1 = read_data1_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios followed by random traffic,
// every cycle checked against an array-based reference model.
module tb_register_file;

    localparam int W = 32;
    localparam int A = 5;
    localparam int N = 1 << A;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         write_enable;
    logic [A-1:0] write_addr;
    logic [W-1:0] write_data;
    logic [A-1:0] read_addr0;
    logic [A-1:0] read_addr1;
    logic [W-1:0] read_data0;
    logic [W-1:0] read_data1;

    int numVectors = 0;
    int numMiscompares = 0;

    logic [W-1:0] modelMem [N];
    logic [W-1:0] expData0;
    logic [W-1:0] expData1;

    always #5 clk = ~clk;

    register_file #(.word_size(W), .addr_size(A)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_addr0  (read_addr0),
        .read_addr1  (read_addr1),
        .read_data0  (read_data0),
        .read_data1  (read_data1)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    // Drives one cycle, advances the model by the architectural rules, then
    // checks both read ports just after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic we,
                                 input logic [A-1:0] wa, input logic [W-1:0] wd,
                                 input logic [A-1:0] ra0, input logic [A-1:0] ra1);
        rst          = r;
        stall        = s;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr0   = ra0;
        read_addr1   = ra1;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) modelMem[i] = '0;
            expData0 = '0;
            expData1 = '0;
        end else begin
            if (we && wa != 0) modelMem[wa] = wd;
            if (!s) begin
                expData0 = (ra0 == 0) ? '0 : modelMem[ra0];
                expData1 = (ra1 == 0) ? '0 : modelMem[ra1];
            end
        end
        #1;
        checkOutput("model_rd0", read_data0, expData0);
        checkOutput("model_rd1", read_data1, expData1);
    endtask

    initial begin
        logic         r, s, we;
        logic [A-1:0] wa, ra0, ra1;
        logic [W-1:0] wd;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_rd0", read_data0, 32'h0);
        checkOutput("reset_rd1", read_data1, 32'h0);

        // Reset clears previously written data
        applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 5, 5);
        applyStimulus(0, 0, 0, 0, 0, 5, 5);
        checkOutput("rstclr_rd0", read_data0, 32'h0);
        checkOutput("rstclr_rd1", read_data1, 32'h0);

        // Basic write then read; unwritten register reads zero
        applyStimulus(0, 0, 1, 3, 32'h12345678, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 4, 3);
        checkOutput("basic_rd1", read_data1, 32'h12345678);
        checkOutput("basic_rd0", read_data0, 32'h0);

        // Same-cycle bypass on both ports
        applyStimulus(0, 0, 1, 7, 32'hA5A5A5A5, 7, 7);
        checkOutput("bypass_rd0", read_data0, 32'hA5A5A5A5);
        checkOutput("bypass_rd1", read_data1, 32'hA5A5A5A5);

        // Register 0 ignores writes
        applyStimulus(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        checkOutput("r0_same", read_data0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_next", read_data0, 32'h0);

        // Stall holds outputs while the array still takes writes
        applyStimulus(0, 0, 1, 2, 32'h11, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 2, 2);
        checkOutput("stall_pre", read_data0, 32'h11);
        applyStimulus(0, 1, 1, 2, 32'h22, 2, 2);
        checkOutput("stall_hold1", read_data0, 32'h11);
        applyStimulus(0, 1, 0, 0, 0, 5, 5);
        checkOutput("stall_hold2", read_data0, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 2, 2);
        checkOutput("stall_release", read_data0, 32'h22);

        // Reset wins over a simultaneous write
        applyStimulus(1, 0, 1, 9, 32'h55, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 9, 9);
        checkOutput("rstprio_rd0", read_data0, 32'h0);
        checkOutput("rstprio_rd1", read_data1, 32'h0);

        // Random traffic, biased toward low addresses to provoke bypass/aliasing
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 39) == 0);
            s   = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 2) != 0);
            wa  = ($urandom_range(0, 1) == 0) ? A'($urandom_range(0, 7)) : A'($urandom);
            wd  = $urandom;
            ra0 = ($urandom_range(0, 1) == 0) ? A'($urandom_range(0, 7)) : A'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : A'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) ra0 = wa;
            applyStimulus(r, s, we, wa, wd, ra0, ra1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Two-read, one-write general-purpose register file for the basic CPU datapath.
- Sits directly upstream of the operand-select multiplexer:
  - read_data1 feeds the mux data-0 leg.
  - An immediate feeds the data-1 leg.
- The write port is driven by the write-back stage.
- Reads are registered (1-cycle latency), with write-first bypass and a stall hold.

Parameters:
- word_size, 32, width of every register and data port.
- addr_size, 5, register index width; the file holds 2**addr_size registers.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  when 1, read outputs hold their current values. Writes still occur.
- write_enable  input  1  when 1, write_data is stored to write_addr on the clock edge.
- write_addr  input  addr_size  destination register index.
- write_data  input  word_size  data to be written.
- read_addr0  input  addr_size  source register index, port 0.
- read_addr1  input  addr_size  source register index, port 1.
- read_data0  output  word_size  registered contents of read_addr0.
- read_data1  output  word_size  registered contents of read_addr1 (feeds the operand mux).

Behaviour:
- Storage: 2**addr_size registers of word_size bits each.
- Register 0 is hardwired zero:
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0.
- Reset, on a rising edge with rst=1:
  - All registers are cleared to 0.
  - read_data0 = 0 and read_data1 = 0.
  - rst has priority over write_enable and stall; a write presented in the reset cycle is lost.
  - Reset asserted mid-operation behaves identically, with no partial state retained.
- Write: on a rising edge with rst=0, write_enable=1 and write_addr!=0, register[write_addr] <= write_data.
- Read, 1-cycle latency: on a rising edge with rst=0 and stall=0, read_dataN <= value of register[read_addrN] as seen after this cycle's write.
- Write-first bypass:
  - Condition: write_enable=1, write_addr==read_addrN and write_addr!=0 in the same cycle.
  - read_dataN captures write_data, not the stale register value.
  - Applies independently to each port; both ports may bypass the same write simultaneously.
- Stall:
  - With stall=1 and rst=0, read_data0 and read_data1 keep their previous values.
  - A write in a stall cycle still updates the array.
  - The first non-stalled read afterwards returns the new value.
- Both read ports may address the same register; both return identical data.
- Outputs change only on clock edges; there is no combinational path from any input to any output.
- No X propagation: every register has a defined value after the first reset edge.

Test Plan:
- Reset clears: write 0xDEADBEEF to r5, assert rst one cycle, then read r5 on both ports -> read_data0 = read_data1 = 0x00000000 one cycle after the read address is applied.
- Basic write/read: write 0x12345678 to r3 (cycle 1), set read_addr1=3 (cycle 2) -> read_data1 = 0x12345678 after the cycle-2 edge. read_addr0=4 (never written) -> 0.
- Bypass: in one cycle write_enable=1, write_addr=7, write_data=0xA5A5A5A5, read_addr0=read_addr1=7 -> both outputs = 0xA5A5A5A5 after that same edge.
- r0 hardwired: write 0xFFFFFFFF to r0 with read_addr0=0 in the same cycle, then read r0 again next cycle -> read_data0 = 0 both times.
- Stall:
  - Read r2 (=0x11) and hold stall=1 while writing r2=0x22 -> read_data0 stays 0x11 for all stalled cycles.
  - Deassert stall -> 0x22 on the next edge.
- Reset priority: rst=1, write_enable=1, write_addr=9, write_data=0x55 in the same cycle, then read r9 -> 0.
